scope_trigger_ctrl: RTL and testbench

SCOPE_TRIGGER_CTRL -- requirements
Module: scope_trigger_ctrl

---
 rtl/scope_trigger_ctrl.sv | 165 ++++++++++++++++
 tb/tb_scope_trigger_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scope_trigger_ctrl.sv
// Oscilloscope trigger/capture controller: holdoff, edge trigger with auto timeout,
// one-frame capture into a display frame buffer, and a display handshake.
module scope_trigger_ctrl #(
    parameter int unsigned DATA_W       = 12,
    parameter int unsigned DEPTH        = 640,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned HOLDOFF      = 4,
    parameter int unsigned AUTO_TIMEOUT = 1000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic [1:0]        mode,
    input  logic              arm,
    input  logic              disp_ack,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_valid,
    output logic              trig_forced,
    output logic              busy
);
    localparam int unsigned HOLD_W = $clog2(HOLDOFF + 2);
    localparam int unsigned TO_W   = $clog2(AUTO_TIMEOUT + 2);
    localparam logic [1:0]  MODE_AUTO   = 2'b00;
    localparam logic [1:0]  MODE_SINGLE = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_HOLD, S_WAIT_TRIG, S_CAPTURE, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_mode, w_mode_nxt;
    logic                r_slope, w_slope_nxt;
    logic [DATA_W-1:0]   r_level, w_level_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt, w_hold_cnt_nxt;
    logic [TO_W-1:0]     r_to_cnt, w_to_cnt_nxt;
    logic [DATA_W-1:0]   r_prev, w_prev_nxt;
    logic                r_prev_valid, w_prev_valid_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic                r_wr_en, w_wr_en_nxt;
    logic [ADDR_W-1:0]   r_wr_addr, w_wr_addr_nxt;
    logic [DATA_W-1:0]   r_wr_data, w_wr_data_nxt;
    logic                r_frame_valid, r_trig_forced, w_trig_forced_nxt, r_busy;
    logic                w_rise, w_fall, w_hit, w_timeout;

    // Edge detection against the level latched at the last IDLE visit
    assign w_rise    = r_prev_valid && (r_prev < r_level) && (sample_in >= r_level);
    assign w_fall    = r_prev_valid && (r_prev > r_level) && (sample_in <= r_level);
    assign w_hit     = r_slope ? w_fall : w_rise;
    assign w_timeout = (r_mode == MODE_AUTO) && (r_to_cnt == TO_W'(AUTO_TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_mode_nxt        = r_mode;
        w_slope_nxt       = r_slope;
        w_level_nxt       = r_level;
        w_hold_cnt_nxt    = r_hold_cnt;
        w_to_cnt_nxt      = r_to_cnt;
        w_prev_nxt        = r_prev;
        w_prev_valid_nxt  = r_prev_valid;
        w_addr_nxt        = r_addr;
        w_wr_en_nxt       = 1'b0;
        w_wr_addr_nxt     = r_wr_addr;
        w_wr_data_nxt     = r_wr_data;
        w_trig_forced_nxt = r_trig_forced;
        case (r_state)
            S_IDLE: begin
                w_mode_nxt     = mode;
                w_slope_nxt    = trig_slope;
                w_level_nxt    = trig_level;
                w_hold_cnt_nxt = '0;
                if ((mode != MODE_SINGLE) || arm) w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if ((HOLDOFF == 0) ||
                    (sample_en && (r_hold_cnt == HOLD_W'(HOLDOFF - 1)))) begin
                    w_state_nxt      = S_WAIT_TRIG;
                    w_prev_valid_nxt = 1'b0;
                    w_to_cnt_nxt     = '0;
                end else if (sample_en) begin
                    w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            S_WAIT_TRIG: begin
                if (sample_en) begin
                    if (w_hit || w_timeout) begin
                        w_wr_en_nxt       = 1'b1;
                        w_wr_addr_nxt     = '0;
                        w_wr_data_nxt     = sample_in;
                        w_trig_forced_nxt = !w_hit;
                        w_addr_nxt        = ADDR_W'(1);
                        w_state_nxt       = (DEPTH == 1) ? S_DONE : S_CAPTURE;
                    end else begin
                        w_prev_nxt       = sample_in;
                        w_prev_valid_nxt = 1'b1;
                        if (r_mode == MODE_AUTO) w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                    end
                end
            end
            S_CAPTURE: begin
                if (sample_en) begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = r_addr;
                    w_wr_data_nxt = sample_in;
                    if (r_addr == ADDR_W'(DEPTH - 1)) w_state_nxt = S_DONE;
                    else                              w_addr_nxt  = r_addr + ADDR_W'(1);
                end
            end
            S_DONE: begin
                if (disp_ack) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; status flags follow the next state
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_mode        <= '0;
            r_slope       <= 1'b0;
            r_level       <= '0;
            r_hold_cnt    <= '0;
            r_to_cnt      <= '0;
            r_prev        <= '0;
            r_prev_valid  <= 1'b0;
            r_addr        <= '0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_frame_valid <= 1'b0;
            r_trig_forced <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_mode        <= w_mode_nxt;
            r_slope       <= w_slope_nxt;
            r_level       <= w_level_nxt;
            r_hold_cnt    <= w_hold_cnt_nxt;
            r_to_cnt      <= w_to_cnt_nxt;
            r_prev        <= w_prev_nxt;
            r_prev_valid  <= w_prev_valid_nxt;
            r_addr        <= w_addr_nxt;
            r_wr_en       <= w_wr_en_nxt;
            r_wr_addr     <= w_wr_addr_nxt;
            r_wr_data     <= w_wr_data_nxt;
            r_frame_valid <= (w_state_nxt == S_DONE);
            r_trig_forced <= w_trig_forced_nxt;
            r_busy        <= (w_state_nxt != S_IDLE);
        end
    end

    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign frame_valid = r_frame_valid;
    assign trig_forced = r_trig_forced;
    assign busy        = r_busy;

endmodule

// File: tb/tb_scope_trigger_ctrl.sv
// Directed bench for scope_trigger_ctrl: normal/falling/auto/single captures,
// display handshake hold, and reset abandoning a capture.
module tb_scope_trigger_ctrl;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned ADDR_W = 10;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              sample_en = 1'b0;
    logic [DATA_W-1:0] sample_in = '0;
    logic [DATA_W-1:0] trig_level = 12'd2048;
    logic              trig_slope = 1'b0;
    logic [1:0]        mode = 2'b01;
    logic              arm = 1'b0;
    logic              disp_ack = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              frame_valid;
    logic              trig_forced;
    logic              busy;

    int n_vec = 0;
    int n_bad = 0;

    int                wr_total = 0;
    int                seq_err = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [DATA_W-1:0] mem [0:1023];

    scope_trigger_ctrl #(
        .DATA_W(12), .DEPTH(640), .ADDR_W(10), .HOLDOFF(4), .AUTO_TIMEOUT(1000)
    ) dut (
        .clock(clock), .reset_n(reset_n), .sample_en(sample_en), .sample_in(sample_in),
        .trig_level(trig_level), .trig_slope(trig_slope), .mode(mode), .arm(arm),
        .disp_ack(disp_ack), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_valid(frame_valid), .trig_forced(trig_forced), .busy(busy)
    );

    always #5 clock = ~clock;

    // Frame-buffer write monitor
    always @(negedge clock) begin
        if (wr_en) begin
            wr_total      <= wr_total + 1;
            mem[wr_addr]  <= wr_data;
            last_addr     <= wr_addr;
            if ((wr_addr != '0 && wr_addr != 10'(last_addr + 10'd1)) || wr_addr > 10'd639)
                seq_err <= seq_err + 1;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic strobe(input logic [DATA_W-1:0] v);
        step();
        sample_en = 1'b1;
        sample_in = v;
        step();
        sample_en = 1'b0;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        sample_en = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    function automatic logic [DATA_W-1:0] sine_at(input int k);
        real r;
        r = 2048.0 + 1800.0 * $sin(2.0 * 3.14159265358979 * real'(k % 64) / 64.0);
        return 12'($rtoi(r + 0.5));
    endfunction

    function automatic logic [DATA_W-1:0] stim(input int kind, input int k);
        case (kind)
            0:       return 12'(16 * k);
            1:       return sine_at(k);
            default: return 12'd500;
        endcase
    endfunction

    task automatic run_frame(input int kind, input string tag, output int n);
        n = 0;
        while (!frame_valid && n < 2000) begin
            strobe(stim(kind, n));
            n++;
        end
        chk({tag, "_frame_done"}, 32'(frame_valid), 32'd1);
    endtask

    initial begin
        int base, sbase, n, kt;
        bit found;

        // Reset state
        step(); step(); step();
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_frame_valid", 32'(frame_valid), 0);
        chk("rst_trig_forced", 32'(trig_forced), 0);
        chk("rst_busy", 32'(busy), 0);

        // Normal, rising, level 2048, ramp step 16: trigger on strobe 129
        mode = 2'b01; trig_slope = 1'b0; trig_level = 12'd2048;
        do_reset();
        chk("norm_busy", 32'(busy), 1);
        base = wr_total; sbase = seq_err;
        run_frame(0, "norm", n);
        chk("norm_strobes", 32'(n), 768);
        chk("norm_writes", 32'(wr_total - base), 640);
        chk("norm_seq", 32'(seq_err - sbase), 0);
        chk("norm_addr0", 32'(mem[0]), 2048);
        chk("norm_addr300", 32'(mem[300]), 2752);
        chk("norm_addr639", 32'(mem[639]), 4080);
        chk("norm_forced", 32'(trig_forced), 0);
        chk("norm_last_addr", 32'(wr_addr), 639);

        // DONE holds for 10000 cycles with strobes ignored
        base = wr_total;
        for (int i = 0; i < 5000; i++) strobe(12'd4000);
        chk("done_hold_fv", 32'(frame_valid), 1);
        chk("done_hold_writes", 32'(wr_total - base), 0);
        disp_ack = 1'b1;
        step();
        disp_ack = 1'b0;
        chk("done_ack_fv", 32'(frame_valid), 0);

        // Falling, level 1000, sine
        mode = 2'b01; trig_slope = 1'b1; trig_level = 12'd1000;
        do_reset();
        kt = -1;
        for (int k = 5; k < 200 && kt < 0; k++)
            if (sine_at(k - 1) > 12'd1000 && sine_at(k) <= 12'd1000) kt = k;
        base = wr_total; sbase = seq_err;
        run_frame(1, "fall", n);
        chk("fall_strobes", 32'(n), 32'(kt + 640));
        chk("fall_writes", 32'(wr_total - base), 640);
        chk("fall_addr0", 32'(mem[0]), 32'(sine_at(kt)));
        chk("fall_addr0_le", 32'(mem[0] <= 12'd1000), 1);
        chk("fall_addr1", 32'(mem[1]), 32'(sine_at(kt + 1)));
        chk("fall_addr639", 32'(mem[639]), 32'(sine_at(kt + 639)));
        chk("fall_seq", 32'(seq_err - sbase), 0);

        // Auto, constant 500: forced trigger on WAIT strobe 1000 (strobe 1004 overall)
        mode = 2'b00; trig_slope = 1'b0; trig_level = 12'd2048;
        do_reset();
        base = wr_total;
        for (int i = 0; i < 1003; i++) strobe(12'd500);
        chk("auto_no_early_write", 32'(wr_total - base), 0);
        strobe(12'd500);
        chk("auto_trig_wr_en", 32'(wr_en), 1);
        chk("auto_trig_addr", 32'(wr_addr), 0);
        chk("auto_trig_data", 32'(wr_data), 500);
        chk("auto_trig_forced", 32'(trig_forced), 1);
        n = 0;
        while (!frame_valid && n < 700) begin
            strobe(12'd500);
            n++;
        end
        chk("auto_frame_done", 32'(frame_valid), 1);
        chk("auto_writes", 32'(wr_total - base), 640);
        chk("auto_addr639", 32'(mem[639]), 500);
        chk("auto_forced_held", 32'(trig_forced), 1);

        // Auto: real trigger on the timeout strobe wins
        do_reset();
        for (int i = 0; i < 1003; i++) strobe(12'd500);
        strobe(12'd3000);
        chk("auto_real_wr_en", 32'(wr_en), 1);
        chk("auto_real_data", 32'(wr_data), 3000);
        chk("auto_real_forced", 32'(trig_forced), 0);

        // Single mode: nothing without arm, one frame after arm
        mode = 2'b10; trig_slope = 1'b0; trig_level = 12'd2048;
        do_reset();
        base = wr_total;
        for (int i = 0; i < 5000; i++) strobe(12'(16 * i));
        chk("single_idle_busy", 32'(busy), 0);
        chk("single_idle_writes", 32'(wr_total - base), 0);
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk("single_armed_busy", 32'(busy), 1);
        run_frame(0, "single", n);
        chk("single_strobes", 32'(n), 768);
        chk("single_writes", 32'(wr_total - base), 640);
        disp_ack = 1'b1;
        step();
        disp_ack = 1'b0;
        chk("single_ack_fv", 32'(frame_valid), 0);
        base = wr_total;
        for (int i = 0; i < 200; i++) strobe(12'(16 * i));
        chk("single_stays_idle", 32'(busy), 0);
        chk("single_after_writes", 32'(wr_total - base), 0);

        // Reset at capture address 300 abandons the frame
        mode = 2'b01; trig_slope = 1'b0; trig_level = 12'd2048;
        do_reset();
        n = 0; found = 1'b0;
        while (!found && n < 1000) begin
            strobe(12'(16 * n));
            n++;
            if (wr_en && wr_addr == 10'd300) found = 1'b1;
        end
        chk("mid_reach_300", 32'(found), 1);
        reset_n   = 1'b0;
        sample_en = 1'b1;
        sample_in = 12'd77;
        step();
        sample_en = 1'b0;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_wr_en", 32'(wr_en), 0);
        chk("mid_rst_fv", 32'(frame_valid), 0);
        chk("mid_rst_wr_addr", 32'(wr_addr), 0);
        reset_n = 1'b1;
        step();
        n = 0; found = 1'b0;
        while (!found && n < 400) begin
            strobe(12'(16 * n));
            n++;
            if (wr_en) found = 1'b1;
        end
        chk("restart_found", 32'(found), 1);
        chk("restart_addr", 32'(wr_addr), 0);
        chk("restart_data", 32'(wr_data), 2048);
        chk("restart_strobes", 32'(n), 129);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
